// File: rtl/ramchip_sync_if.sv
// -----------------------------------------------------------------------------
// ramchip_sync_if
//
// Local memory bus bundle for the clocked scratch RAM (ramchip_sync).
//
// Signals:
//   address     word address, $clog2(ADDRESS_SIZE) bits
//   data_in     write data, WORD_SIZE bits
//   byte_en     per-lane write enable, active high, WORD_SIZE/BYTE_WIDTH bits
//   CS          chip select, active low
//   WE          write enable, active low (WE=1 selects a read)
//   OE          output enable, active low (gates the RAM's data_out pins)
//   data_valid  one-cycle strobe marking a read result at the RAM output
//   busy        high while the RAM is running its power-up clear
//
// Modports:
//   master  the bus requester (drives requests, observes status)
//   slave   the RAM itself
//
// data_out is not carried here: it is a tri-stated pin and is kept as a plain
// port on the RAM so the high-impedance driver sits directly on a module
// boundary.
// -----------------------------------------------------------------------------
interface ramchip_sync_if #(
    parameter int ADDRESS_SIZE = 64,
    parameter int WORD_SIZE    = 32,
    parameter int BYTE_WIDTH   = 8
);
    localparam int ADDR_WIDTH = (ADDRESS_SIZE > 1) ? $clog2(ADDRESS_SIZE) : 1;
    localparam int NUM_LANES  = WORD_SIZE / BYTE_WIDTH;

    logic [ADDR_WIDTH-1:0] address;
    logic [WORD_SIZE-1:0]  data_in;
    logic [NUM_LANES-1:0]  byte_en;
    logic                  CS;
    logic                  WE;
    logic                  OE;
    logic                  data_valid;
    logic                  busy;

    modport master (
        output address,
        output data_in,
        output byte_en,
        output CS,
        output WE,
        output OE,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  address,
        input  data_in,
        input  byte_en,
        input  CS,
        input  WE,
        input  OE,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/ramchip_sync.sv
// -----------------------------------------------------------------------------
// ramchip_sync
//
// Synchronous single-port word RAM with per-byte write enables, a registered
// read pipeline of configurable depth, and a self-clearing sequence that runs
// after every reset so the contents start from a known all-zero state.
//
// Parameters:
//   ADDRESS_SIZE  memory depth in words (any value >= 1, not only powers of 2)
//   WORD_SIZE     word width in bits, a multiple of BYTE_WIDTH
//   BYTE_WIDTH    bits per byte lane
//   READ_LATENCY  edges from read acceptance to data_valid, 1..4
//
// Ports:
//   clk       single clock, all state changes on the rising edge
//   rst       synchronous, active-high reset
//   bus       ramchip_sync_if.slave: address, data_in, byte_en, CS, WE, OE in;
//             data_valid, busy out
//   data_out  read data from the pipeline output register, high-Z when OE=1
//
// Behaviour summary:
//   - After reset the RAM is busy for ADDRESS_SIZE edges, zeroing one word
//     per edge. Requests seen while busy are dropped.
//   - A request is accepted on an edge where CS=0, busy=0 and rst=0.
//     WE=0 writes the enabled byte lanes; WE=1 launches a read.
//   - Out-of-range writes are discarded; out-of-range reads still complete
//     with data_valid and a zero word.
//   - The output register keeps the last read result until a newer one lands.
// -----------------------------------------------------------------------------
module ramchip_sync #(
    parameter int ADDRESS_SIZE = 64,
    parameter int WORD_SIZE    = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ramchip_sync_if.slave        bus,
    output wire [WORD_SIZE-1:0]  data_out
);

    localparam int ADDR_WIDTH = (ADDRESS_SIZE > 1) ? $clog2(ADDRESS_SIZE) : 1;
    localparam int NUM_LANES  = WORD_SIZE / BYTE_WIDTH;

    // Last word touched by the clear sequence; reaching it ends the clear.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDRESS_SIZE - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic                  busy_reg;

    // -------------------------------------------------------------------------
    // Storage and read pipeline
    // -------------------------------------------------------------------------
    logic [WORD_SIZE-1:0]    mem [ADDRESS_SIZE];
    logic [WORD_SIZE-1:0]    pipe_data_reg [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid_reg;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic                  in_range;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic [NUM_LANES-1:0]  lane_we;

    // Compare in 32 bits so a power-of-two depth does not wrap the bound to 0.
    assign in_range  = (32'(bus.address) < 32'(ADDRESS_SIZE));

    // busy_reg is low exactly when the FSM sits in READY, so it doubles as
    // the "ready to accept" qualifier.
    assign accept    = !rst && !busy_reg && !bus.CS;
    assign rd_accept = accept && bus.WE;
    assign wr_accept = accept && !bus.WE && in_range;

    // The clear sequence borrows the write port: all lanes, zero data, at
    // the counter address. Reset edges themselves never write the array.
    assign clearing  = !rst && (state_reg == CLEAR);
    assign wr_addr   = clearing ? counter_reg : bus.address;
    assign wr_data   = clearing ? '0 : bus.data_in;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_we
            assign lane_we[gi] = clearing || (wr_accept && bus.byte_en[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Clear/ready FSM with registered busy output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            counter_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    counter_reg <= counter_reg + 1'b1;
                    if (counter_reg == LAST_ADDR) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end
                end
                READY: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    state_reg <= CLEAR;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory array write port, one enable per byte lane.
    // No reset here so the array maps onto block RAM.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_we[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline.
    // Stage 0 is the registered array read; each later stage moves forward
    // one edge. A stage only loads data when the stage behind it carries a
    // valid result, so the last stage (the output register) holds its word
    // between reads. Reset flushes every stage, discarding in-flight reads.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_reg[k] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= rd_accept;
            if (rd_accept) begin
                // Out-of-range reads complete normally but carry a zero word.
                pipe_data_reg[0] <= in_range ? mem[bus.address] : '0;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                if (pipe_valid_reg[k-1]) begin
                    pipe_data_reg[k] <= pipe_data_reg[k-1];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. OE only gates the pins; data_valid is reported regardless.
    // -------------------------------------------------------------------------
    assign bus.data_valid = pipe_valid_reg[READ_LATENCY-1];
    assign bus.busy       = busy_reg;
    assign data_out       = bus.OE ? {WORD_SIZE{1'bz}} : pipe_data_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_ramchip_sync.sv
// -----------------------------------------------------------------------------
// tb_ramchip_sync
//
// Directed bench for ramchip_sync. Three instances share one clock:
//   u0: ADDRESS_SIZE=64, READ_LATENCY=1  (clear, byte enables, OE/CS, rst mid-clear)
//   u1: ADDRESS_SIZE=64, READ_LATENCY=3  (pipelined back-to-back reads)
//   u2: ADDRESS_SIZE=48, READ_LATENCY=2  (busy drop, out-of-range, rst mid-read)
// Inputs change just after the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_ramchip_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    wire [31:0] dout0, dout1, dout2;

    int vectors     = 0;
    int miscompares = 0;

    ramchip_sync_if #(.ADDRESS_SIZE(64), .WORD_SIZE(32), .BYTE_WIDTH(8)) if0 ();
    ramchip_sync_if #(.ADDRESS_SIZE(64), .WORD_SIZE(32), .BYTE_WIDTH(8)) if1 ();
    ramchip_sync_if #(.ADDRESS_SIZE(48), .WORD_SIZE(32), .BYTE_WIDTH(8)) if2 ();

    ramchip_sync #(.ADDRESS_SIZE(64), .WORD_SIZE(32), .BYTE_WIDTH(8), .READ_LATENCY(1)) u0 (
        .clk(clk), .rst(rst0), .bus(if0), .data_out(dout0)
    );
    ramchip_sync #(.ADDRESS_SIZE(64), .WORD_SIZE(32), .BYTE_WIDTH(8), .READ_LATENCY(3)) u1 (
        .clk(clk), .rst(rst1), .bus(if1), .data_out(dout1)
    );
    ramchip_sync #(.ADDRESS_SIZE(48), .WORD_SIZE(32), .BYTE_WIDTH(8), .READ_LATENCY(2)) u2 (
        .clk(clk), .rst(rst2), .bus(if2), .data_out(dout2)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_differs(input string tag, input logic [31:0] got, input logic [31:0] not_exp);
        vectors++;
        assert (got !== not_exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected anything but %h", tag, got, not_exp);
        end
    endtask

    function automatic logic get_valid(input int u);
        case (u)
            0:       return if0.data_valid;
            1:       return if1.data_valid;
            default: return if2.data_valid;
        endcase
    endfunction

    function automatic logic get_busy(input int u);
        case (u)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic [31:0] get_dout(input int u);
        case (u)
            0:       return dout0;
            1:       return dout1;
            default: return dout2;
        endcase
    endfunction

    task automatic drive(input int u, input logic cs, input logic we, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        case (u)
            0: begin if0.CS = cs; if0.WE = we; if0.address = a; if0.data_in = d; if0.byte_en = be; end
            1: begin if1.CS = cs; if1.WE = we; if1.address = a; if1.data_in = d; if1.byte_en = be; end
            default: begin if2.CS = cs; if2.WE = we; if2.address = a; if2.data_in = d; if2.byte_en = be; end
        endcase
    endtask

    task automatic idle(input int u);
        drive(u, 1'b1, 1'b1, 6'd0, 32'd0, 4'd0);
    endtask

    // One request for one edge; returns at the falling edge after acceptance.
    task automatic req(input int u, input logic we, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        drive(u, 1'b0, we, a, d, be);
        @(negedge clk);
        idle(u);
    endtask

    task automatic write_word(input int u, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        req(u, 1'b0, a, d, be);
    endtask

    // Read, expect silence until the latency expires, one valid cycle, then silence.
    task automatic read_check(input int u, input logic [5:0] a, input logic [31:0] exp,
                              input int lat, input string tag);
        req(u, 1'b1, a, 32'd0, 4'd0);
        repeat (lat - 1) begin
            check({tag, "_early_valid"}, 32'(get_valid(u)), 32'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(get_valid(u)), 32'd1);
        check({tag, "_data"}, get_dout(u), exp);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(get_valid(u)), 32'd0);
    endtask

    // Count falling-edge samples with busy high, starting now; bounded.
    task automatic busy_count(input int u, input int exp, input string tag);
        int n = 0;
        while (get_busy(u) && n < 300) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n0, n2;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        idle(0); idle(1); idle(2);
        if0.OE = 1'b0; if1.OE = 1'b0; if2.OE = 1'b0;

        // Two reset edges, then reset values.
        repeat (2) @(negedge clk);
        check("rst_busy_u0",  32'(if0.busy), 32'd1);
        check("rst_valid_u0", 32'(if0.data_valid), 32'd0);
        check("rst_dout_u0",  dout0, 32'd0);
        check("rst_busy_u2",  32'(if2.busy), 32'd1);
        check("rst_valid_u1", 32'(if1.data_valid), 32'd0);

        // Release reset; count the clear on u0 (64) and u2 (48). A write to
        // an already-cleared u2 word during clear must be dropped.
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        n0 = 0; n2 = 0;
        for (int c = 0; c < 300; c++) begin
            if (if0.busy) n0++;
            if (if2.busy) n2++;
            if (!if0.busy && !if2.busy) break;
            if (c == 3) drive(2, 1'b0, 1'b0, 6'd1, 32'h12345678, 4'hF);
            else        idle(2);
            @(negedge clk);
        end
        idle(2);
        check("clear_len_u0", n0, 64);
        check("clear_len_u2", n2, 48);

        // Cleared contents, data_valid exactly one cycle after acceptance.
        read_check(0, 6'd0,  32'h0, 1, "clr_rd0");
        read_check(0, 6'd31, 32'h0, 1, "clr_rd31");
        read_check(0, 6'd63, 32'h0, 1, "clr_rd63");

        // Byte-enable merge, then an all-zero byte_en no-op.
        write_word(0, 6'd5, 32'hDEADBEEF, 4'b1111);
        write_word(0, 6'd5, 32'h11223344, 4'b0101);
        read_check(0, 6'd5, 32'hDE22BE44, 1, "be_merge");
        write_word(0, 6'd5, 32'hFFFFFFFF, 4'b0000);
        read_check(0, 6'd5, 32'hDE22BE44, 1, "be_none");

        // OE gating: pins released during a hidden read, valid still pulses.
        write_word(0, 6'd9, 32'h0BADF00D, 4'hF);
        if0.OE = 1'b1;
        req(0, 1'b1, 6'd9, 32'd0, 4'd0);
        check("oe_valid", 32'(if0.data_valid), 32'd1);
        check_differs("oe_hiz", dout0, 32'h0BADF00D);
        if0.OE = 1'b0;
        #1;
        check("oe_held", dout0, 32'h0BADF00D);
        @(negedge clk);

        // CS=1 with WE=0 must not write.
        drive(0, 1'b1, 1'b0, 6'd9, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        idle(0);
        read_check(0, 6'd9, 32'h0BADF00D, 1, "cs_block");

        // Pipelined reads on u1 (latency 3): four back-to-back.
        for (int k = 0; k < 4; k++) write_word(1, 6'(k), 32'hA0 + 32'(k), 4'hF);
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1, 1'b0, 1'b1, 6'(c), 32'd0, 4'd0);
            else       idle(1);
            @(negedge clk);
            check($sformatf("pipe_valid_c%0d", c), 32'(if1.data_valid),
                  (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5)
                check($sformatf("pipe_data_c%0d", c), dout1, 32'hA0 + 32'(c - 2));
        end
        idle(1);

        // u2: dropped busy write, out-of-range, top in-range word.
        read_check(2, 6'd1, 32'h0, 2, "busy_drop");
        write_word(2, 6'd50, 32'hCAFEBABE, 4'hF);
        read_check(2, 6'd50, 32'h0, 2, "oor");
        write_word(2, 6'd47, 32'h47474747, 4'hF);
        read_check(2, 6'd47, 32'h47474747, 2, "top_word");

        // Reset one cycle after a read is accepted: result discarded.
        req(2, 1'b1, 6'd47, 32'd0, 4'd0);
        rst2 = 1'b1;
        @(negedge clk);
        check("rst_rd_valid", 32'(if2.data_valid), 32'd0);
        check("rst_rd_busy", 32'(if2.busy), 32'd1);
        rst2 = 1'b0;
        busy_count(2, 48, "rst_rd_clear");
        read_check(2, 6'd47, 32'h0, 2, "rst_rd_wiped");

        // Reset 20 cycles into a clear: full clear repeats.
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (20) @(negedge clk);
        check("midclr_busy", 32'(if0.busy), 32'd1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        busy_count(0, 64, "midclr_len");
        read_check(0, 6'd5, 32'h0, 1, "midclr_wiped");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ramchip_sync.md
# ramchip_sync

Synchronous, parametrised successor to the asynchronous RAM chip model. It provides a single-port word memory with:
- active-low chip-select, write-enable and output-enable;
- per-byte write enables;
- a configurable registered read pipeline with a valid strobe;
- a self-clearing initialisation sequence after reset.

It sits on the local memory bus wherever a clocked scratch RAM with a deterministic power-up state is needed.

## Interface
Parameters:
- ADDRESS_SIZE, 64, memory depth in words (need not be a power of two)
- WORD_SIZE, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per byte lane
- READ_LATENCY, 1, cycles from read acceptance to data_valid; legal range 1..4

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- address  in  $clog2(ADDRESS_SIZE)  word address
- data_in  in  WORD_SIZE  write data
- byte_en  in  WORD_SIZE/BYTE_WIDTH  per-lane write enable, active high
- CS  in  1  chip select, active low
- WE  in  1  write enable, active low (WE=1 means read)
- OE  in  1  output enable, active low; combinational gate on data_out only
- data_out  out  WORD_SIZE  read data; 'z when OE=1
- data_valid  out  1  one-cycle strobe marking a read result at the pipeline output
- busy  out  1  high while the clear sequence runs; requests are ignored

## Operation
- States: CLEAR, READY.
- rst=1 at an edge:
  - state<=CLEAR, clear counter<=0, busy<=1;
  - read pipeline flushed: all stage valids 0, data 0;
  - memory contents untouched by the reset edge itself.
- CLEAR, at each edge with rst=0:
  - mem[counter]<=0, counter<=counter+1;
  - when counter==ADDRESS_SIZE-1, state<=READY and busy<=0.
  - CS/WE/address/data_in are ignored.
- READY, request accepted at an edge when CS=0, busy=0 and rst=0.
  - Write (WE=0): for each lane i with byte_en[i]=1, mem[address] lane i <= data_in lane i. Other lanes keep their value. byte_en all zero is a no-op.
  - Read (WE=1): mem[address] enters pipeline stage 1. It advances one stage per cycle and reaches the output register after READ_LATENCY edges. Reads are read-first: a read is not combined with a write in the same cycle (single port), so there is no same-cycle read/write hazard.
- Address out of range (address >= ADDRESS_SIZE):
  - write ignored;
  - read still produces data_valid, with data 0.
- CS=1: no access, but the pipeline keeps draining. Back-to-back reads are fully pipelined, one per cycle.
- Output:
  - data_out = pipeline output register when OE=0, otherwise 'z;
  - data_valid is independent of OE;
  - the output register holds its last value until the next read result lands.

## Timing
- Reset values: busy=1, data_valid=0, output register 0 (data_out=0 if OE=0, else 'z), state CLEAR, counter 0.
- Clear duration: with rst deasserted before edge E0, busy falls after edge E0+ADDRESS_SIZE-1. The first request can be accepted at edge E0+ADDRESS_SIZE.
- Write: the memory is updated at the accepting edge. A read of the same address accepted at the next edge returns the new data.
- Read accepted at edge N: data_valid=1 and data present during the cycle after edge N+READ_LATENCY-1, for one cycle. Throughput is 1 per cycle.
- rst mid-clear: the counter restarts from 0, so the full ADDRESS_SIZE-cycle clear repeats.
- rst mid-read: in-flight reads are discarded and data_valid stays 0.
- Requests presented while busy=1 are dropped silently. No queueing and no error flag.

## Test plan
- Reset/clear, defaults: pulse rst 2 cycles. Check busy=1 for exactly 64 cycles after rst falls. Then read addresses 0, 31, 63 and check each returns 0x00000000 with data_valid exactly 1 cycle after acceptance.
- Byte-enable write: write 0xDEADBEEF to address 5 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101. Read address 5 and expect 0xDE22BE44.
- Pipelined reads, READ_LATENCY=3: write addresses 0..3 = 0xA0..0xA3. Issue 4 consecutive reads. Expect data_valid on 4 consecutive cycles starting 3 cycles after the first read, with data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- OE and CS gating: hold OE=1 during a read and expect data_out='z while data_valid still pulses. Lower OE and expect the held word to appear. Apply CS=1 with WE=0 and expect memory unchanged on readback.
- Busy and out-of-range, ADDRESS_SIZE=48: a write issued during clear is dropped (read afterwards returns 0). A write to address 50 is ignored, and a read of address 50 returns 0 with data_valid.
- Reset mid-operation: assert rst on cycle 20 of clear and expect busy for a further full 64 cycles. Assert rst one cycle after a read is accepted with READ_LATENCY=2 and expect no data_valid.
